md_issue_ctrl: RTL

//   Issue/hazard sequencer for the multiply-divide unit. Decodes the E-stage HI/LO op,

---
 rtl/md_issue_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// Multiply-divide issue/hazard sequencer: accepts E-stage mult/div, times
// them to HI/LO commit, and produces the D-stage stall.
module md_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] E_md_op,
  input  logic       D_md_use,
  input  logic       M_cp0_req,
  output logic       md_start,
  output logic [2:0] md_op,
  output logic       md_mt_we,
  output logic       md_busy,
  output logic [4:0] md_cnt,
  output logic       md_commit,
  output logic       D_md_stall,
  output logic       md_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [4:0] MUL_N = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic [4:0] r_cnt, w_cnt_nxt;
  logic       r_commit, w_commit_nxt;
  logic       r_err, w_err_nxt;

  logic w_idle;
  logic w_is_md;
  logic w_is_mul;
  logic w_is_mt;
  logic w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_is_mul = (E_md_op == 4'd1) || (E_md_op == 4'd2);
  assign w_is_md  = w_is_mul
                 || (E_md_op == 4'd3) || (E_md_op == 4'd4);
  assign w_is_mt  = (E_md_op == 4'd7) || (E_md_op == 4'd8);
  assign w_accept = !M_cp0_req && w_idle && w_is_md;

  assign md_start   = w_accept;
  assign md_mt_we   = !M_cp0_req && w_idle && w_is_mt;
  assign md_busy    = (r_state == BUSY);
  assign md_op      = r_op;
  assign md_cnt     = r_cnt;
  assign md_commit  = r_commit;
  assign md_err     = r_err;
  assign D_md_stall = D_md_use && (md_busy || md_start);

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_commit_nxt = 1'b0;
    w_err_nxt    = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = BUSY;
          w_op_nxt    = E_md_op[2:0];
          w_cnt_nxt   = w_is_mul ? MUL_N : DIV_N;
        end
      end
      BUSY: begin
        // A cp0 request freezes the in-flight op rather than aborting it
        if (!M_cp0_req) begin
          if (w_is_md || w_is_mt) w_err_nxt = 1'b1;
          if (r_cnt > 5'd1) begin
            w_cnt_nxt = r_cnt - 5'd1;
          end else begin
            w_cnt_nxt    = 5'd0;
            w_op_nxt     = 3'd0;
            w_commit_nxt = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= 3'd0;
      r_cnt    <= 5'd0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_commit <= w_commit_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule
